// File: rtl/chip8_fetch.sv
// chip8_fetch: CHIP-8 instruction fetch stage.
// Builds big-endian 16-bit opcodes from byte memory and owns the PC.
module chip8_fetch #(
    parameter int unsigned       ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'('h200)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       op_code,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    input  logic              skip
);

    typedef enum logic [2:0] {
        START,
        REQ_HI,
        WAIT_HI,
        REQ_LO,
        WAIT_LO,
        VALID,
        DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] last_pc;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;

    assign redirect = pc_load | skip;
    assign target   = pc_load ? pc_load_addr : last_pc + ADDR_W'(4);
    assign next_pc  = redirect ? target : fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= START;
            mem_req  <= 1'b0;
            mem_addr <= PC_RESET;
            op_valid <= 1'b0;
            op_code  <= 16'h0000;
            op_pc    <= PC_RESET;
            fetch_pc <= PC_RESET;
            last_pc  <= PC_RESET - ADDR_W'(2);
        end else begin
            mem_req <= 1'b0;
            unique case (state)
                START: begin
                    fetch_pc <= next_pc;
                    mem_addr <= next_pc;
                    mem_req  <= 1'b1;
                    state    <= REQ_HI;
                end
                REQ_HI, REQ_LO: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        mem_addr <= target;
                        mem_req  <= 1'b1;
                        state    <= REQ_HI;
                    end else begin
                        state <= (state == REQ_HI) ? WAIT_HI : WAIT_LO;
                    end
                end
                WAIT_HI, WAIT_LO: begin
                    if (redirect) begin
                        // The in-flight byte belongs to the old stream.
                        fetch_pc <= target;
                        if (mem_rvalid) begin
                            mem_addr <= target;
                            mem_req  <= 1'b1;
                            state    <= REQ_HI;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_rvalid) begin
                        if (state == WAIT_HI) begin
                            op_code[15:8] <= mem_rdata;
                            mem_addr      <= fetch_pc + ADDR_W'(1);
                            mem_req       <= 1'b1;
                            state         <= REQ_LO;
                        end else begin
                            op_code[7:0] <= mem_rdata;
                            op_pc        <= fetch_pc;
                            op_valid     <= 1'b1;
                            state        <= VALID;
                        end
                    end
                end
                VALID: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        mem_addr <= target;
                        mem_req  <= 1'b1;
                        op_valid <= 1'b0;
                        state    <= REQ_HI;
                    end else if (op_ready) begin
                        last_pc  <= op_pc;
                        fetch_pc <= op_pc + ADDR_W'(2);
                        mem_addr <= op_pc + ADDR_W'(2);
                        mem_req  <= 1'b1;
                        op_valid <= 1'b0;
                        state    <= REQ_HI;
                    end
                end
                DRAIN: begin
                    fetch_pc <= next_pc;
                    if (mem_rvalid) begin
                        mem_addr <= next_pc;
                        mem_req  <= 1'b1;
                        state    <= REQ_HI;
                    end
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_fetch.sv
// tb_chip8_fetch: scoreboard bench for the CHIP-8 fetch stage.
// A latency-programmable byte memory answers requests; ops are checked on arrival.
module tb_chip8_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_code;
    logic [11:0] op_pc;
    logic        pc_load;
    logic [11:0] pc_load_addr;
    logic        skip;

    chip8_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_pc        (op_pc),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .skip         (skip)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem [0:4095];
    logic [11:0] addr_log [$];
    logic [27:0] exp_q [$];
    int          lat = 1;
    logic        pend;
    logic [11:0] paddr;
    int          cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: one pending request, response after lat cycles.
    initial begin
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_req) begin
                pend = 1'b1;
                paddr = mem_addr;
                cnt = lat;
                addr_log.push_back(mem_addr);
            end
            #1;
            mem_rvalid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem[paddr];
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic push_op(input logic [11:0] pc);
        logic [11:0] pc1;
        pc1 = pc + 12'd1;
        exp_q.push_back({pc, mem[pc], mem[pc1]});
    endtask

    task automatic expect_op(input string tag);
        int cyc;
        logic [27:0] e;
        cyc = 0;
        while (!op_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'h0;
        check({tag, "_valid"}, 32'(op_valid), 32'd1);
        check({tag, "_code"}, 32'(op_code), 32'(e[15:0]));
        check({tag, "_pc"}, 32'(op_pc), 32'(e[27:16]));
    endtask

    task automatic accept();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic redirect(input logic ld, input logic sk,
                            input logic [11:0] a);
        pc_load = ld;
        skip = sk;
        pc_load_addr = a;
        @(negedge clk);
        pc_load = 1'b0;
        skip = 1'b0;
    endtask

    task automatic check_log(input string tag, input int idx,
                             input logic [11:0] exp);
        logic [11:0] v;
        v = (idx < addr_log.size()) ? addr_log[idx] : 12'hxxx;
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_valid"}, 32'(op_valid), 32'd0);
        check({tag, "_code"}, 32'(op_code), 32'h0);
        check({tag, "_pc"}, 32'(op_pc), 32'h200);
        check({tag, "_addr"}, 32'(mem_addr), 32'h200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        mem[12'h204] = 8'h6A;
        mem[12'h205] = 8'h07;
        mem[12'hFFF] = 8'hA2;
        mem[12'h000] = 8'h2A;
        op_ready = 1'b0;
        pc_load = 1'b0;
        skip = 1'b0;
        pc_load_addr = '0;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        push_op(12'h200);
        cyc = 0;
        while (!op_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("first_latency", 32'(cyc), 32'd5);
        expect_op("first");
        check_log("first_hi_addr", 0, 12'h200);
        check_log("first_lo_addr", 1, 12'h201);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_code", 32'(op_code), 32'h1234);
            check("hold_pc", 32'(op_pc), 32'h200);
        end
        accept();
        check("next_req", 32'(mem_req), 32'd1);
        check("next_addr", 32'(mem_addr), 32'h202);

        addr_log.delete();
        redirect(1'b0, 1'b1, 12'h000);
        push_op(12'h204);
        expect_op("skip");
        check_log("skip_addr", 1, 12'h204);
        accept();

        addr_log.delete();
        redirect(1'b1, 1'b1, 12'h300);
        push_op(12'h300);
        expect_op("skip_load");
        check_log("skip_load_addr", 1, 12'h300);
        accept();

        addr_log.delete();
        lat = 3;
        @(negedge clk);
        redirect(1'b1, 1'b0, 12'h456);
        push_op(12'h456);
        expect_op("drain");
        check("drain_log_len", 32'(addr_log.size()), 32'd3);
        check_log("drain_hi_addr", 1, 12'h456);
        check_log("drain_lo_addr", 2, 12'h457);

        lat = 1;
        accept();
        redirect(1'b1, 1'b0, 12'hFFF);
        addr_log.delete();
        push_op(12'hFFF);
        expect_op("wrap");
        check("wrap_code_const", 32'(op_code), 32'hA22A);
        check_log("wrap_hi_addr", 0, 12'hFFF);
        check_log("wrap_lo_addr", 1, 12'h000);
        accept();
        check("wrap_next_req", 32'(mem_req), 32'd1);
        check("wrap_next_addr", 32'(mem_addr), 32'h001);

        lat = 3;
        cyc = 0;
        while (!(mem_req && mem_addr == 12'h002) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_req_lo", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) @(negedge clk);
        check_reset("held_reset");
        rst_n = 1'b1;
        addr_log.delete();
        push_op(12'h200);
        expect_op("post_reset");
        check_log("post_reset_addr", 0, 12'h200);
        check_log("post_reset_lo", 1, 12'h201);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
